nf_bin2bcd_seq: RTL and testbench
=================================

// Module: nf_bin2bcd_seq
// PURPOSE
//  Iterative binary-to-BCD converter (shift-and-add-3, one bit per clock) for the board display path.
//  Takes an unsigned binary value from the core side (GPIO/counter data) and produces packed BCD
//  digits plus a leading-zero blank mask. Output feeds the static seven-segment decoder's hex input.
//  One conversion in flight; start/busy/done handshake; result held until the next conversion completes.
// PARAMETERS
//  BIN_W  16  width of binary input; 2 <= BIN_W <= 32
//  DIG_N  6   number of BCD digits produced; must satisfy 10**DIG_N > 2**BIN_W-1 ($error at elaboration otherwise)
// PORTS
//  clk      in   1          system clock; all state on rising edge
//  resetn   in   1          asynchronous active-low reset
//  start    in   1          conversion request; sampled only in IDLE
//  bin_i    in   BIN_W      unsigned value; captured on the edge that accepts start
//  busy     out  1          high while a conversion is in progress
//  done     out  1          one-cycle pulse: bcd_o/lz_mask valid (new) from this cycle
//  bcd_o    out  4*DIG_N    packed BCD, digit k at [4k+3:4k], digit 0 = units
//  lz_mask  out  DIG_N      bit k = 1 -> digit k is a leading zero (blank it); bit 0 always 0
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd_o=0, lz_mask=0, internal regs 0.
//  States: IDLE -> SHIFT -> DONE -> IDLE.
//  IDLE: start=1 at edge E0 -> bin shift reg <= bin_i, BCD work reg <= 0, bit counter <= BIN_W, go SHIFT, busy<=1.
//   start=0 -> stay; outputs hold.
//  SHIFT: per cycle: every work digit >=5 gets +3 (all digits corrected in parallel, combinational),
//   then {work,shift} shifted left 1 (bin MSB enters work bit 0); counter-1.
//   After BIN_W shift cycles (edges E1..E_BIN_W) go DONE.
//  DONE (one cycle, edge E_BIN_W+1): bcd_o <= work, lz_mask <= computed from work, done<=1, busy<=0, -> IDLE.
//  Latency: done high in the cycle following edge E0+BIN_W+1 (BIN_W=16: 17 edges after accept).
//  busy rises on E0, falls on the same edge done rises; busy and done never high together.
//  done is exactly one cycle; deasserts next edge regardless of start.
//  start while busy (SHIFT/DONE): ignored, no queueing, bin_i changes ignored.
//  start high in the cycle done is high: FSM is IDLE -> accepted; back-to-back throughput BIN_W+2 cycles.
//  start held high continuously: conversions repeat back-to-back on bin_i sampled at each accept.
//  Correction arithmetic per digit is 4-bit, no carry between digits except via the shift; work reg is
//   4*DIG_N bits; the MSB shifted out of the top digit is always 0 given the parameter constraint.
//  lz_mask: for k = DIG_N-1 down to 1, bit k = 1 iff digits k..DIG_N-1 are all 0; bit 0 = 0 (value 0 shows "0").
//  bcd_o/lz_mask change only on DONE edge or reset; stable otherwise (no glitching to display).
//  Reset mid-conversion: aborts immediately, all outputs to reset values, no done pulse afterwards.
//  No X propagation: every register has a reset value; unused counter states return to IDLE.
// TESTING
//  T1 reset then start with bin_i=0 -> done exactly 17 cycles after accept, bcd_o=24'h000000, lz_mask=6'b111110.
//  T2 bin_i=2019 -> bcd_o=24'h002019, lz_mask=6'b110000; busy high 17 cycles then low with done.
//  T3 bin_i=65535 (max) -> bcd_o=24'h065535, lz_mask=6'b100000; then 9 -> 24'h000009, 6'b111110.
//  T4 start pulsed at cycles 3 and 8 after accept with bin_i changed to 1234 -> ignored, result is first value, one done only.
//  T5 start held high, bin_i=100 then 42 -> done pulses 18 cycles apart, bcd_o 24'h000100 then 24'h000042.
//  T6 resetn low at cycle 9 of a conversion of 777 -> busy=0,bcd_o=0 immediately (async); no done; next start works.
//  Scoreboard: every done compared against integer reference conversion; assert busy&done never both 1.

Source files
------------

// File: rtl/nf_bin2bcd_seq.sv
// Iterative binary-to-BCD converter for the board display path.
// Uses shift-and-add-3 and converts one input bit per clock, with a
// start/busy/done handshake. The result is held until the next conversion completes.
//
// Ports:
//   clk      system clock, rising edge
//   resetn   asynchronous active-low reset
//   start    conversion request, sampled only while idle
//   bin_i    unsigned binary value, captured on the edge that accepts start
//   busy     high while a conversion is in progress
//   done     one-cycle pulse; bcd_o/lz_mask carry the new result from this cycle
//   bcd_o    packed BCD, digit k at [4k+3:4k], digit 0 = units
//   lz_mask  bit k set -> digit k is a leading zero; bit 0 always 0
module nf_bin2bcd_seq #(
    parameter int unsigned BIN_W = 16,
    parameter int unsigned DIG_N = 6
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [BIN_W-1:0]     bin_i,
    output logic                 busy,
    output logic                 done,
    output logic [4*DIG_N-1:0]   bcd_o,
    output logic [DIG_N-1:0]     lz_mask
);

    localparam int unsigned BCD_W = 4 * DIG_N;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    // True when DIG_N decimal digits can hold the largest BIN_W-bit value.
    function automatic bit capacity_ok(input int unsigned bw, input int unsigned dn);
        longint unsigned p10;
        longint unsigned maxv;
        p10 = 64'd1;
        if (dn >= 19) return 1'b1;
        for (int unsigned i = 0; i < dn; i++) p10 = p10 * 64'd10;
        maxv = (64'd1 << bw) - 64'd1;
        return p10 > maxv;
    endfunction

    // Elaboration-time parameter checks.
    if (BIN_W < 2 || BIN_W > 32) begin : g_bad_bin_w
        $error("nf_bin2bcd_seq: BIN_W=%0d outside 2..32", BIN_W);
    end
    if (!capacity_ok(BIN_W, DIG_N)) begin : g_bad_dig_n
        $error("nf_bin2bcd_seq: DIG_N=%0d too small for BIN_W=%0d", DIG_N, BIN_W);
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t               state_q, state_nxt;
    logic [BIN_W-1:0]     shift_q, shift_nxt;
    logic [BCD_W-1:0]     work_q, work_nxt;
    logic [CNT_W-1:0]     cnt_q, cnt_nxt;
    logic                 busy_nxt, done_nxt;
    logic [BCD_W-1:0]     bcd_nxt;
    logic [DIG_N-1:0]     lz_nxt;

    logic [BCD_W-1:0]     work_adj_c;
    logic [DIG_N-1:0]     lz_c;
    logic                 all_zero_c;

    // Add-3 correction on every digit >= 5, all digits in parallel.
    always_comb begin
        work_adj_c = work_q;
        for (int k = 0; k < int'(DIG_N); k++) begin
            if (work_q[4*k +: 4] >= 4'd5) begin
                work_adj_c[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero mask, scanned from the top digit down; units digit never blanked.
    always_comb begin
        lz_c       = '0;
        all_zero_c = 1'b1;
        for (int k = int'(DIG_N) - 1; k >= 1; k--) begin
            all_zero_c = all_zero_c & (work_q[4*k +: 4] == 4'd0);
            lz_c[k]    = all_zero_c;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt = state_q;
        shift_nxt = shift_q;
        work_nxt  = work_q;
        cnt_nxt   = cnt_q;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        bcd_nxt   = bcd_o;
        lz_nxt    = lz_mask;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    shift_nxt = bin_i;
                    work_nxt  = '0;
                    cnt_nxt   = CNT_W'(BIN_W);
                    busy_nxt  = 1'b1;
                    state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (cnt_q == '0) begin
                    // Unreachable counter value: abandon the conversion cleanly.
                    busy_nxt  = 1'b0;
                    state_nxt = S_IDLE;
                end else begin
                    // The bit leaving the top digit is always 0 given the capacity check.
                    {work_nxt, shift_nxt} = {work_adj_c, shift_q} << 1;
                    cnt_nxt = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                bcd_nxt   = work_q;
                lz_nxt    = lz_c;
                done_nxt  = 1'b1;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
            default: begin
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            work_q  <= '0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            bcd_o   <= '0;
            lz_mask <= '0;
        end else begin
            state_q <= state_nxt;
            shift_q <= shift_nxt;
            work_q  <= work_nxt;
            cnt_q   <= cnt_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            bcd_o   <= bcd_nxt;
            lz_mask <= lz_nxt;
        end
    end

endmodule

// File: tb/tb_nf_bin2bcd_seq.sv
// Directed self-checking bench for nf_bin2bcd_seq (BIN_W=16, DIG_N=6).
module tb_nf_bin2bcd_seq;

    logic        clk;
    logic        resetn;
    logic        start;
    logic [15:0] bin_i;
    logic        busy;
    logic        done;
    logic [23:0] bcd_o;
    logic [5:0]  lz_mask;

    int n_checks = 0;
    int n_pass   = 0;
    logic [23:0] last_bcd;

    nf_bin2bcd_seq #(.BIN_W(16), .DIG_N(6)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .bin_i   (bin_i),
        .busy    (busy),
        .done    (done),
        .bcd_o   (bcd_o),
        .lz_mask (lz_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Integer reference: decimal digits of v.
    function automatic logic [23:0] ref_bcd(input int unsigned v);
        logic [23:0] r;
        int unsigned x;
        x = v;
        r = '0;
        for (int k = 0; k < 6; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [5:0] ref_lz(input logic [23:0] b);
        logic [5:0] m;
        logic z;
        m = '0;
        z = 1'b1;
        for (int k = 5; k >= 1; k--) begin
            z    = z & (b[4*k +: 4] == 4'd0);
            m[k] = z;
        end
        return m;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // busy and done must never be high together.
    always @(negedge clk) begin
        n_checks++;
        assert (!(busy === 1'b1 && done === 1'b1)) n_pass++;
        else $error("FAIL busy_done_overlap: observed busy=%b done=%b expected not both 1", busy, done);
    end

    // One full conversion; optional start pulses while busy carrying 1234.
    task automatic run_conv(input int unsigned v, input bit glitch);
        int  cyc;
        int  busy_cnt;
        bit  seen;
        logic [23:0] exp_bcd;
        exp_bcd = ref_bcd(v);
        start = 1'b1;
        bin_i = 16'(v);
        @(posedge clk); #1;
        start = 1'b0;
        bin_i = 16'($urandom);
        check("busy_on_accept", 32'(busy), 32'd1);
        check("hold_prev_result", 32'(bcd_o), 32'(last_bcd));
        cyc      = 0;
        busy_cnt = 1;
        seen     = 1'b0;
        while (!seen && cyc < 40) begin
            if (glitch && (cyc == 2 || cyc == 7)) begin
                start = 1'b1;
                bin_i = 16'd1234;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (busy) busy_cnt++;
            if (done) seen = 1'b1;
        end
        start = 1'b0;
        check("done_latency", 32'(cyc), 32'd17);
        check("busy_cycles", 32'(busy_cnt), 32'd17);
        check("bcd_value", 32'(bcd_o), 32'(exp_bcd));
        check("lz_value", 32'(lz_mask), 32'(ref_lz(exp_bcd)));
        last_bcd = exp_bcd;
        @(posedge clk); #1;
        check("done_one_cycle", 32'(done), 32'd0);
        check("result_held", 32'(bcd_o), 32'(exp_bcd));
    endtask

    initial begin
        int d1;
        int d2;
        int n_done;

        resetn   = 1'b0;
        start    = 1'b0;
        bin_i    = '0;
        last_bcd = '0;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_bcd", 32'(bcd_o), 32'd0);
        check("rst_lz", 32'(lz_mask), 32'd0);
        #10 resetn = 1'b1;
        @(posedge clk); #1;

        // T1..T3: basic conversions and extremes.
        run_conv(0, 1'b0);
        check("t1_lz_zero", 32'(lz_mask), 32'b111110);
        run_conv(2019, 1'b0);
        check("t2_bcd", 32'(bcd_o), 32'h002019);
        run_conv(65535, 1'b0);
        check("t3_bcd_max", 32'(bcd_o), 32'h065535);
        check("t3_lz_max", 32'(lz_mask), 32'b100000);
        run_conv(9, 1'b0);
        check("t3_lz_nine", 32'(lz_mask), 32'b111110);
        run_conv(10000, 1'b0);

        // T4: start pulses while busy are ignored, exactly one done.
        run_conv(4321, 1'b1);
        check("t4_first_value", 32'(bcd_o), 32'h004321);
        n_done = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("t4_no_extra_done", 32'(n_done), 32'd0);

        // T5: start held high, back-to-back conversions.
        start = 1'b1;
        bin_i = 16'd100;
        @(posedge clk); #1;
        bin_i = 16'd42;
        check("t5_busy", 32'(busy), 32'd1);
        d1 = -1;
        d2 = -1;
        for (int c = 1; c <= 45; c++) begin
            @(posedge clk); #1;
            if (c == 18) start = 1'b0;
            if (done) begin
                if (d1 < 0) begin
                    d1 = c;
                    check("t5_bcd_first", 32'(bcd_o), 32'h000100);
                    check("t5_lz_first", 32'(lz_mask), 32'b111000);
                end else if (d2 < 0) begin
                    d2 = c;
                    check("t5_bcd_second", 32'(bcd_o), 32'h000042);
                end
            end
        end
        check("t5_first_latency", 32'(d1), 32'd17);
        check("t5_spacing", 32'(d2 - d1), 32'd18);
        last_bcd = 24'h000042;

        // T6: async reset in the middle of a conversion.
        start = 1'b1;
        bin_i = 16'd777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #4 resetn = 1'b0;
        #1;
        check("t6_busy_async", 32'(busy), 32'd0);
        check("t6_bcd_async", 32'(bcd_o), 32'd0);
        check("t6_lz_async", 32'(lz_mask), 32'd0);
        check("t6_done_async", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        n_done = 0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk); #1;
            if (done) n_done++;
        end
        check("t6_no_done_after_reset", 32'(n_done), 32'd0);
        check("t6_bcd_still_zero", 32'(bcd_o), 32'd0);
        last_bcd = '0;
        run_conv(58, 1'b0);
        check("t6_lz_after", 32'(lz_mask), 32'b111100);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
